// File: rtl/apu_package.sv
// Shared APU definitions: field widths for the integer multiplier port and
// packed request/response records.
package apu_package;

  localparam int WAPUTAG           = 5;
  localparam int DSP_WIDTH         = 32;
  localparam int WOP_INT_MULT      = 3;
  localparam int NDSFLAGS_INT_MULT = 5;

  typedef struct packed {
    logic [DSP_WIDTH-1:0] res;
    logic [WAPUTAG-1:0]   tag;
    logic [1:0]           status;
  } apu_int_rsp_t;

  typedef struct packed {
    logic [WOP_INT_MULT-1:0]      op;
    logic [DSP_WIDTH-1:0]         opa;
    logic [DSP_WIDTH-1:0]         opb;
    logic [DSP_WIDTH-1:0]         opc;
    logic [NDSFLAGS_INT_MULT-1:0] flags;
    logic [WAPUTAG-1:0]           tag;
  } apu_int_req_t;

endpackage

// File: rtl/apu_resp_fifo.sv
// Small synchronous FIFO with wrap-around pointers; a push into a full FIFO
// is accepted only when a pop happens on the same edge.
module apu_resp_fifo #(
  parameter int WIDTH = 8,
  parameter int DEPTH = 2
) (
  input  logic             clk_i,
  input  logic             rst_ni,
  input  logic             push_i,
  input  logic [WIDTH-1:0] wdata_i,
  input  logic             pop_i,
  output logic [WIDTH-1:0] rdata_o,
  output logic             full_o,
  output logic             empty_o
);

  localparam int PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int CNT_W = $clog2(DEPTH + 1);

  logic [WIDTH-1:0] mem [DEPTH];
  logic [PTR_W-1:0] wr_ptr, rd_ptr;
  logic [CNT_W-1:0] count;
  logic             do_push, do_pop;

  function automatic logic [PTR_W-1:0] ptr_inc(input logic [PTR_W-1:0] p);
    return (p == PTR_W'(DEPTH - 1)) ? '0 : p + PTR_W'(1);
  endfunction

  assign full_o  = (count == CNT_W'(DEPTH));
  assign empty_o = (count == '0);
  assign do_pop  = pop_i && !empty_o;
  assign do_push = push_i && (!full_o || do_pop);
  assign rdata_o = mem[rd_ptr];

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (do_push) wr_ptr <= ptr_inc(wr_ptr);
      if (do_pop)  rd_ptr <= ptr_inc(rd_ptr);
      case ({do_push, do_pop})
        2'b10:   count <= count + CNT_W'(1);
        2'b01:   count <= count - CNT_W'(1);
        default: count <= count;
      endcase
    end
  end

  // Storage carries data only; validity is tracked entirely by count.
  always_ff @(posedge clk_i) begin
    if (do_push) mem[wr_ptr] <= wdata_i;
  end

endmodule

// File: rtl/apu_int_mult_issue.sv
// Issue/collect block for the shared APU integer multiplier: one-entry hold
// register, credit-based issue, in-order response FIFO and sticky error flag.
module apu_int_mult_issue
  import apu_package::*;
#(
  parameter int TAG_WIDTH = WAPUTAG,
  parameter int DEPTH     = 2
) (
  input  logic                         clk_i,
  input  logic                         rst_ni,
  input  logic                         req_valid_i,
  output logic                         req_ready_o,
  input  logic [WOP_INT_MULT-1:0]      req_op_i,
  input  logic [DSP_WIDTH-1:0]         req_opa_i,
  input  logic [DSP_WIDTH-1:0]         req_opb_i,
  input  logic [DSP_WIDTH-1:0]         req_opc_i,
  input  logic [NDSFLAGS_INT_MULT-1:0] req_flags_i,
  input  logic [TAG_WIDTH-1:0]         req_tag_i,
  output logic                         unit_en_o,
  output logic [WOP_INT_MULT-1:0]      unit_op_o,
  output logic [DSP_WIDTH-1:0]         unit_opa_o,
  output logic [DSP_WIDTH-1:0]         unit_opb_o,
  output logic [DSP_WIDTH-1:0]         unit_opc_o,
  output logic [NDSFLAGS_INT_MULT-1:0] unit_flags_o,
  output logic [TAG_WIDTH-1:0]         unit_tag_o,
  input  logic                         unit_ready_i,
  input  logic                         unit_valid_i,
  input  logic [DSP_WIDTH-1:0]         unit_res_i,
  input  logic [TAG_WIDTH-1:0]         unit_tag_i,
  input  logic [1:0]                   unit_status_i,
  output logic                         unit_ack_o,
  output logic                         rsp_valid_o,
  input  logic                         rsp_ready_i,
  output logic [DSP_WIDTH-1:0]         rsp_res_o,
  output logic [TAG_WIDTH-1:0]         rsp_tag_o,
  output logic [1:0]                   rsp_status_o,
  output logic                         err_o
);

  localparam int CNT_W = $clog2(DEPTH + 1);
  localparam int RSP_W = DSP_WIDTH + TAG_WIDTH + 2;

  logic                         hold_valid;
  logic [WOP_INT_MULT-1:0]      hold_op;
  logic [DSP_WIDTH-1:0]         hold_opa, hold_opb, hold_opc;
  logic [NDSFLAGS_INT_MULT-1:0] hold_flags;
  logic [TAG_WIDTH-1:0]         hold_tag;

  logic [CNT_W-1:0] used, outst;
  logic             issue, accept, pop, push, spurious;
  logic             fifo_full, fifo_empty;
  logic [RSP_W-1:0] fifo_rdata;

  assign issue       = hold_valid && unit_ready_i && (used < CNT_W'(DEPTH));
  assign req_ready_o = !hold_valid || issue;
  assign accept      = req_valid_i && req_ready_o;

  assign unit_en_o    = issue;
  assign unit_op_o    = issue ? hold_op    : '0;
  assign unit_opa_o   = issue ? hold_opa   : '0;
  assign unit_opb_o   = issue ? hold_opb   : '0;
  assign unit_opc_o   = issue ? hold_opc   : '0;
  assign unit_flags_o = issue ? hold_flags : '0;
  assign unit_tag_o   = issue ? hold_tag   : '0;

  // A zero-latency unit answers in the issue cycle, so issue alone qualifies the ack.
  assign unit_ack_o = unit_valid_i && ((outst != '0) || issue);
  assign spurious   = unit_valid_i && (outst == '0) && !issue;
  assign push       = unit_ack_o;

  assign rsp_valid_o = !fifo_empty;
  assign pop         = rsp_valid_o && rsp_ready_i;
  assign {rsp_res_o, rsp_tag_o, rsp_status_o} = rsp_valid_o ? fifo_rdata : '0;

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      hold_valid <= 1'b0;
      used       <= '0;
      outst      <= '0;
      err_o      <= 1'b0;
    end else begin
      if (accept)     hold_valid <= 1'b1;
      else if (issue) hold_valid <= 1'b0;
      case ({issue, pop})
        2'b10:   used <= used + CNT_W'(1);
        2'b01:   used <= used - CNT_W'(1);
        default: used <= used;
      endcase
      case ({issue, unit_ack_o})
        2'b10:   outst <= outst + CNT_W'(1);
        2'b01:   outst <= outst - CNT_W'(1);
        default: outst <= outst;
      endcase
      // Credits make an overflowing push unreachable; flag it if it ever happens.
      if (spurious || (push && fifo_full && !pop)) err_o <= 1'b1;
    end
  end

  always_ff @(posedge clk_i) begin
    if (accept) begin
      hold_op    <= req_op_i;
      hold_opa   <= req_opa_i;
      hold_opb   <= req_opb_i;
      hold_opc   <= req_opc_i;
      hold_flags <= req_flags_i;
      hold_tag   <= req_tag_i;
    end
  end

  apu_resp_fifo #(
    .WIDTH (RSP_W),
    .DEPTH (DEPTH)
  ) u_resp_fifo (
    .clk_i   (clk_i),
    .rst_ni  (rst_ni),
    .push_i  (push),
    .wdata_i ({unit_res_i, unit_tag_i, unit_status_i}),
    .pop_i   (pop),
    .rdata_o (fifo_rdata),
    .full_o  (fifo_full),
    .empty_o (fifo_empty)
  );

endmodule

// File: tb/tb_apu_int_mult_issue.sv
// Scoreboard bench for apu_int_mult_issue with a zero-latency multiplier model.
module tb_apu_int_mult_issue;
  import apu_package::*;

  logic                         clk = 1'b0;
  logic                         rst_ni;
  logic                         req_valid_i, req_ready_o;
  logic [WOP_INT_MULT-1:0]      req_op_i;
  logic [DSP_WIDTH-1:0]         req_opa_i, req_opb_i, req_opc_i;
  logic [NDSFLAGS_INT_MULT-1:0] req_flags_i;
  logic [WAPUTAG-1:0]           req_tag_i;
  logic                         unit_en_o;
  logic [WOP_INT_MULT-1:0]      unit_op_o;
  logic [DSP_WIDTH-1:0]         unit_opa_o, unit_opb_o, unit_opc_o;
  logic [NDSFLAGS_INT_MULT-1:0] unit_flags_o;
  logic [WAPUTAG-1:0]           unit_tag_o;
  logic                         unit_ready_i, unit_valid_i;
  logic [DSP_WIDTH-1:0]         unit_res_i;
  logic [WAPUTAG-1:0]           unit_tag_i;
  logic [1:0]                   unit_status_i;
  logic                         unit_ack_o;
  logic                         rsp_valid_o, rsp_ready_i;
  logic [DSP_WIDTH-1:0]         rsp_res_o;
  logic [WAPUTAG-1:0]           rsp_tag_o;
  logic [1:0]                   rsp_status_o;
  logic                         err_o;

  logic        spur = 1'b0;
  logic [63:0] prod;

  apu_int_rsp_t q[$];
  apu_int_rsp_t mon_e;
  int           pop_cyc[$];
  int           checks = 0, errors = 0;
  int           cyc = 0, en_cnt = 0;

  always #5 clk = ~clk;

  apu_int_mult_issue dut (
    .clk_i(clk), .rst_ni(rst_ni),
    .req_valid_i(req_valid_i), .req_ready_o(req_ready_o),
    .req_op_i(req_op_i), .req_opa_i(req_opa_i), .req_opb_i(req_opb_i),
    .req_opc_i(req_opc_i), .req_flags_i(req_flags_i), .req_tag_i(req_tag_i),
    .unit_en_o(unit_en_o), .unit_op_o(unit_op_o), .unit_opa_o(unit_opa_o),
    .unit_opb_o(unit_opb_o), .unit_opc_o(unit_opc_o), .unit_flags_o(unit_flags_o),
    .unit_tag_o(unit_tag_o), .unit_ready_i(unit_ready_i), .unit_valid_i(unit_valid_i),
    .unit_res_i(unit_res_i), .unit_tag_i(unit_tag_i), .unit_status_i(unit_status_i),
    .unit_ack_o(unit_ack_o), .rsp_valid_o(rsp_valid_o), .rsp_ready_i(rsp_ready_i),
    .rsp_res_o(rsp_res_o), .rsp_tag_o(rsp_tag_o), .rsp_status_o(rsp_status_o),
    .err_o(err_o)
  );

  // Combinational multiplier: answers in the same cycle as the issue strobe.
  assign prod          = 64'(unit_opa_o) * 64'(unit_opb_o);
  assign unit_valid_i  = spur | unit_en_o;
  assign unit_res_i    = spur ? 32'h0000_dead : prod[DSP_WIDTH-1:0];
  assign unit_tag_i    = spur ? 5'h1f : unit_tag_o;
  assign unit_status_i = 2'b00;

  always @(posedge clk) cyc <= cyc + 1;
  always @(negedge clk) if (unit_en_o) en_cnt <= en_cnt + 1;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%0h expected=%0h", name, act, exp);
    end
  endtask

  always @(negedge clk) begin
    if (rst_ni && rsp_valid_o && rsp_ready_i) begin
      if (q.size() == 0) begin
        checks++;
        errors++;
        $display("FAIL rsp_unexpected actual_tag=%0h res=%0h expected=none", rsp_tag_o, rsp_res_o);
      end else begin
        mon_e = q.pop_front();
        chk("rsp_res", 64'(rsp_res_o), 64'(mon_e.res));
        chk("rsp_tag", 64'(rsp_tag_o), 64'(mon_e.tag));
        chk("rsp_status", 64'(rsp_status_o), 64'(mon_e.status));
        pop_cyc.push_back(cyc);
      end
    end
  end

  task automatic send(input logic [2:0] op, input logic [31:0] a, input logic [31:0] b,
                      input logic [4:0] tag, input logic [31:0] r, output int waits);
    logic         acc;
    apu_int_rsp_t e;
    req_valid_i = 1'b1;
    req_op_i    = op;
    req_opa_i   = a;
    req_opb_i   = b;
    req_opc_i   = 32'h0;
    req_flags_i = 5'h0;
    req_tag_i   = tag;
    waits = 0;
    acc   = 1'b0;
    while (!acc && waits < 200) begin
      @(negedge clk);
      acc = req_ready_o;
      @(posedge clk);
      if (!acc) waits++;
    end
    if (acc) begin
      e.res = r;
      e.tag = tag;
      e.status = 2'b00;
      q.push_back(e);
    end else begin
      checks++;
      errors++;
      $display("FAIL send_timeout tag=%0h actual=not_accepted expected=accepted", tag);
    end
    #1;
  endtask

  task automatic idle();
    req_valid_i = 1'b0;
  endtask

  task automatic wait_cycles(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic drain();
    int n = 0;
    while ((q.size() != 0 || rsp_valid_o) && n < 100) begin
      @(posedge clk);
      n++;
    end
    #1;
    chk("drain_done", 64'(n < 100), 64'(1));
  endtask

  logic [31:0] s_a [8] = '{32'd2, 32'd7, 32'd10, 32'd100, 32'hffff, 32'd0, 32'd12, 32'h10000};
  logic [31:0] s_b [8] = '{32'd3, 32'd6, 32'd10, 32'd3, 32'hffff, 32'd9, 32'd12, 32'h10000};
  logic [31:0] s_r [8] = '{32'd6, 32'd42, 32'd100, 32'd300, 32'hfffe0001, 32'd0, 32'd144, 32'd0};

  initial begin
    int w;
    int base;
    rst_ni = 1'b0;
    req_valid_i = 1'b0; req_op_i = '0; req_opa_i = '0; req_opb_i = '0;
    req_opc_i = '0; req_flags_i = '0; req_tag_i = '0;
    unit_ready_i = 1'b1;
    rsp_ready_i  = 1'b1;

    // Reset state
    repeat (3) @(negedge clk);
    chk("rst_req_ready", 64'(req_ready_o), 64'(1));
    chk("rst_unit_en", 64'(unit_en_o), 64'(0));
    chk("rst_rsp_valid", 64'(rsp_valid_o), 64'(0));
    chk("rst_err", 64'(err_o), 64'(0));
    chk("rst_unit_ack", 64'(unit_ack_o), 64'(0));
    chk("rst_rsp_res", 64'(rsp_res_o), 64'(0));
    @(posedge clk); #1;
    rst_ni = 1'b1;
    wait_cycles(1);

    // Single operation: 3 * 5, tag 2
    send(3'd0, 32'd3, 32'd5, 5'h2, 32'd15, w);
    idle();
    @(negedge clk);
    chk("single_en", 64'(unit_en_o), 64'(1));
    chk("single_unit_opa", 64'(unit_opa_o), 64'(3));
    chk("single_unit_tag", 64'(unit_tag_o), 64'(2));
    @(negedge clk);
    chk("single_rsp_valid", 64'(rsp_valid_o), 64'(1));
    chk("single_rsp_res", 64'(rsp_res_o), 64'(15));
    drain();

    // Streaming 8 back-to-back requests
    base = en_cnt;
    pop_cyc.delete();
    for (int i = 0; i < 8; i++) begin
      send(3'd0, s_a[i], s_b[i], 5'(i), s_r[i], w);
      chk("stream_no_wait", 64'(w), 64'(0));
    end
    idle();
    drain();
    chk("stream_en_count", 64'(en_cnt - base), 64'(8));
    chk("stream_pop_count", 64'(pop_cyc.size()), 64'(8));
    if (pop_cyc.size() == 8)
      chk("stream_pop_span", 64'(pop_cyc[7] - pop_cyc[0]), 64'(7));

    // Response back-pressure
    rsp_ready_i = 1'b0;
    base = en_cnt;
    send(3'd0, 32'd11, 32'd2, 5'h10, 32'd22, w);
    send(3'd0, 32'd11, 32'd3, 5'h11, 32'd33, w);
    send(3'd0, 32'd11, 32'd4, 5'h12, 32'd44, w);
    chk("bp_third_accept_wait", 64'(w), 64'(0));
    idle();
    wait_cycles(2);
    @(negedge clk);
    chk("bp_req_ready", 64'(req_ready_o), 64'(0));
    chk("bp_issue_count", 64'(en_cnt - base), 64'(2));
    chk("bp_unit_en", 64'(unit_en_o), 64'(0));
    chk("bp_rsp_valid", 64'(rsp_valid_o), 64'(1));
    chk("bp_rsp_tag_held", 64'(rsp_tag_o), 64'(5'h10));
    fork
      send(3'd0, 32'd11, 32'd5, 5'h13, 32'd55, w);
      begin
        wait_cycles(3);
        rsp_ready_i = 1'b1;
      end
    join
    idle();
    drain();
    chk("bp_total_issues", 64'(en_cnt - base), 64'(4));

    // Unit not ready
    @(posedge clk); #1;
    unit_ready_i = 1'b0;
    send(3'd0, 32'd4, 32'd4, 5'h9, 32'd16, w);
    idle();
    repeat (3) begin
      @(negedge clk);
      chk("nr_unit_en", 64'(unit_en_o), 64'(0));
      chk("nr_unit_opa", 64'(unit_opa_o), 64'(0));
      chk("nr_unit_tag", 64'(unit_tag_o), 64'(0));
    end
    @(posedge clk); #1;
    unit_ready_i = 1'b1;
    @(negedge clk);
    chk("nr_issue_en", 64'(unit_en_o), 64'(1));
    chk("nr_issue_opa", 64'(unit_opa_o), 64'(4));
    drain();

    // Spurious result
    @(posedge clk); #1;
    spur = 1'b1;
    @(negedge clk);
    chk("spur_ack", 64'(unit_ack_o), 64'(0));
    @(posedge clk); #1;
    spur = 1'b0;
    @(negedge clk);
    chk("spur_err_set", 64'(err_o), 64'(1));
    chk("spur_no_rsp", 64'(rsp_valid_o), 64'(0));
    wait_cycles(3);
    @(negedge clk);
    chk("spur_err_sticky", 64'(err_o), 64'(1));

    // Reset mid-operation with two results queued
    @(posedge clk); #1;
    rsp_ready_i = 1'b0;
    send(3'd0, 32'd8, 32'd8, 5'h5, 32'd64, w);
    send(3'd0, 32'd9, 32'd9, 5'h6, 32'd81, w);
    idle();
    wait_cycles(3);
    @(negedge clk);
    chk("mid_rsp_valid", 64'(rsp_valid_o), 64'(1));
    #2;
    rst_ni = 1'b0;
    #1;
    q.delete();
    chk("mid_rst_req_ready", 64'(req_ready_o), 64'(1));
    chk("mid_rst_rsp_valid", 64'(rsp_valid_o), 64'(0));
    chk("mid_rst_unit_en", 64'(unit_en_o), 64'(0));
    chk("mid_rst_err", 64'(err_o), 64'(0));
    chk("mid_rst_rsp_res", 64'(rsp_res_o), 64'(0));
    chk("mid_rst_rsp_tag", 64'(rsp_tag_o), 64'(0));
    wait_cycles(2);
    rst_ni = 1'b1;
    rsp_ready_i = 1'b1;
    repeat (4) begin
      @(negedge clk);
      chk("post_rst_no_stale", 64'(rsp_valid_o), 64'(0));
    end
    @(posedge clk); #1;
    send(3'd0, 32'd6, 32'd7, 5'h3, 32'd42, w);
    idle();
    drain();

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog actual=timeout expected=finish");
    $fatal(1, "watchdog");
  end

endmodule

// File: doc/apu_int_mult_issue.md
# apu_int_mult_issue

Initiator-side issue/collect block for the shared APU integer multiplier port. It sits between a core-side request channel and the multiplier's En/Op/Tag/Valid/Ready/Ack interface. It registers one request, issues it when the unit is ready and result space is reserved, and captures results into a small response FIFO. It then returns results to the core over a valid/ready channel in issue order.

## Interface
- `TAG_WIDTH`, default `WAPUTAG`: tag width.
- `DEPTH`, default 2: response FIFO entries, and the credit limit for requests in flight.

Clock and reset are decided: one clock; reset is asynchronous and active-low.

- `clk_i` in 1: clock.
- `rst_ni` in 1: asynchronous active-low reset.
- `req_valid_i` in 1: core request valid.
- `req_ready_o` out 1: request accepted on the clock edge where valid and ready are both high.
- `req_op_i` in `WOP_INT_MULT`: operator.
- `req_opa_i`, `req_opb_i`, `req_opc_i` in `DSP_WIDTH` each: operands.
- `req_flags_i` in `NDSFLAGS_INT_MULT`: subword, signedness and immediate flags.
- `req_tag_i` in `TAG_WIDTH`: request tag.
- `unit_en_o` out 1: issue strobe to the unit.
- `unit_op_o`, `unit_opa_o`, `unit_opb_o`, `unit_opc_o`, `unit_flags_o`, `unit_tag_o` out (widths as `req_*`): issued request fields.
- `unit_ready_i` in 1: unit can take a request this cycle.
- `unit_valid_i` in 1: unit result valid.
- `unit_res_i` in `DSP_WIDTH`: unit result.
- `unit_tag_i` in `TAG_WIDTH`: result tag.
- `unit_status_i` in 2: result status.
- `unit_ack_o` out 1: result consumed.
- `rsp_valid_o` out 1: core response valid.
- `rsp_ready_i` in 1: core accepts the response.
- `rsp_res_o` out `DSP_WIDTH`: response result.
- `rsp_tag_o` out `TAG_WIDTH`: response tag.
- `rsp_status_o` out 2: response status.
- `err_o` out 1: sticky protocol error.

## Operation
- **Hold register.** One entry (`hold_valid`).
  - `req_ready_o = !hold_valid || issue`.
  - On a request accept, the hold register loads all `req_*` fields.
- **Issue condition.** `issue = hold_valid && unit_ready_i && (used < DEPTH)`.
- **Unit-side outputs.**
  - `unit_en_o = issue`.
  - All `unit_*` request fields equal the hold contents when `issue` is high, else `'0`.
- **Credit counter `used`** (0..`DEPTH`).
  - +1 on issue; −1 on response pop (`rsp_valid_o && rsp_ready_i`).
  - Simultaneous issue and pop leaves it unchanged.
  - Guarantees FIFO space for every outstanding result.
- **Outstanding counter `outst`** (0..`DEPTH`).
  - +1 on issue; −1 on `unit_valid_i && unit_ack_o`.
- **Result capture.**
  - `unit_ack_o = unit_valid_i && (outst != 0 || issue)`.
  - The acked result pushes {`res`, `tag`, `status`} into the FIFO.
  - The combinational unit returns Valid in the same cycle as En; that is legal and is pushed on that edge.
- **Spurious result.** `unit_valid_i` with `outst == 0` and no issue:
  - not acked, not pushed;
  - `err_o` set, and it stays set until reset.
- **Response channel.** FIFO head drives `rsp_*`; `rsp_valid_o` = FIFO not empty. Order is issue order (the unit is in-order).
- **Full FIFO.** With `used == DEPTH`, no issue. `req_ready_o` falls once hold is occupied.
- **Simultaneous push and pop** on a full FIFO is legal, and occupancy stays the same.

## Timing
- **Reset values.** All outputs 0 except `req_ready_o`, which is 1 (hold empty). Counters and FIFO pointers are 0, `hold_valid` is 0, `err_o` is 0.
- **Reset mid-operation.** Asserting `rst_ni` discards the hold register, the FIFO contents and in-flight credits immediately (asynchronous). No response is delivered for them.
- **Latency.**
  - Request accepted at edge N → `unit_en_o` high in cycle N+1 (if the unit is ready and a credit is free).
  - Zero-latency unit → `rsp_valid_o` in cycle N+2.
- **Throughput.** With `DEPTH = 2`, `unit_ready_i = 1` and `rsp_ready_i = 1`: one request per cycle sustained, no bubbles.
- **Back-pressure.** `rsp_ready_i = 0` stalls after `DEPTH` issues. `req_ready_o` then drops after one further accept.
- **Handshake rule.** `rsp_*` fields are held stable while `rsp_valid_o && !rsp_ready_i`.

## Structure
- **Package `apu_package`.**
  - Reuse `WAPUTAG`, `DSP_WIDTH`, `WOP_INT_MULT`, `NDSFLAGS_INT_MULT`.
  - Add a packed struct `apu_int_rsp_t` {`res`, `tag`, `status`}.
  - Add a packed struct `apu_int_req_t` {`op`, `opa`, `opb`, `opc`, `flags`, `tag`}.
- **Sub-module `apu_resp_fifo`.** Parameterised width and depth; synchronous push/pop, full/empty flags, wrap-around pointers.
- **Top level** holds the hold register, both counters and the error flag.

## Test plan
- **Single operation.** Reset, then one request (op MUL, `opa = 3`, `opb = 5`, tag `0x2`) against the unit model → `unit_en_o` one cycle after accept; `rsp_valid_o` two cycles after accept with res 15, tag `0x2`, status 0.
- **Streaming.** 8 back-to-back requests (tags 0..7), `rsp_ready_i = 1` → `req_ready_o` stays 1, one `unit_en_o` per cycle, responses in tag order 0..7 on consecutive cycles.
- **Response back-pressure.** `rsp_ready_i = 0`, 4 requests → exactly 2 issues, third request waits in hold, `req_ready_o = 0` after 3 accepts; release → all 4 delivered in order.
- **Unit not ready.** `unit_ready_i = 0` for 3 cycles with a held request → `unit_en_o` stays 0 and `unit_*` fields read 0; issue occurs in the first cycle `unit_ready_i = 1`.
- **Spurious result.** `unit_valid_i` with nothing outstanding → `unit_ack_o = 0`, FIFO unchanged, `err_o = 1` until reset.
- **Reset mid-operation.** `rst_ni` low with 2 results queued → all outputs at reset values on the next sample; no stale responses after release.
